// File: rtl/state_preparation.sv
`default_nettype none
// ============================================================================
//  Module      : state_preparation
//  Description : Converts a four-bin measurement histogram (|00>..|11>) into
//                a 2-qubit amplitude vector:
//                    amp_k = floor(sqrt(count_k * AMP_ONE^2 / total))
//                One FSM drives a bit-serial restoring divider and a
//                bit-serial restoring square root, shared over the four bins.
//                Imaginary parts are always zero.
//  Ports       : clk, reset (sync, active-high), start (1-cycle request),
//                count0..count3 (8-bit bins), busy, done (1-cycle pulse),
//                amp{00,01,10,11}_{real,imag} (AMP_W signed outputs)
//  Options     : define STATEPREP_ROUND_EN for round-to-nearest square root
//  Revision    : 1.0 - initial release
// ============================================================================
module state_preparation #(
    parameter int AMP_ONE = 181,
    parameter int AMP_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              count0,
    input  logic [7:0]              count1,
    input  logic [7:0]              count2,
    input  logic [7:0]              count3,
    output logic                    busy,
    output logic                    done,
    output logic signed [AMP_W-1:0] amp00_real,
    output logic signed [AMP_W-1:0] amp00_imag,
    output logic signed [AMP_W-1:0] amp01_real,
    output logic signed [AMP_W-1:0] amp01_imag,
    output logic signed [AMP_W-1:0] amp10_real,
    output logic signed [AMP_W-1:0] amp10_imag,
    output logic signed [AMP_W-1:0] amp11_real,
    output logic signed [AMP_W-1:0] amp11_imag
);

    localparam logic [15:0] c_AMP_SQ  = 16'(AMP_ONE * AMP_ONE);
    localparam logic [8:0]  c_AMP_ONE = 9'(AMP_ONE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SUM   = 3'd1,
        S_MUL   = 3'd2,
        S_DIV   = 3'd3,
        S_SQRT  = 3'd4,
        S_STORE = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_cnt    [0:3];
    logic [9:0]  r_total;
    logic [1:0]  r_k;
    logic [4:0]  r_bit;
    // r_num holds the dividend, collects the quotient during DIV, and is then
    // shifted out two bits at a time as the radicand during SQRT.
    logic [23:0] r_num;
    logic [9:0]  r_drem;
    logic [7:0]  r_root;
    logic [9:0]  r_srem;
    logic [8:0]  r_shadow [0:3];
    logic [8:0]  r_amp    [0:3];

    // Divider step: shift in the next dividend bit, subtract if it fits.
    // The 10-bit subtraction is exact whenever it is selected (result < total).
    logic [10:0] w_div_sh;
    logic        w_div_ge;
    logic [9:0]  w_div_sub;
    assign w_div_sh  = {r_drem, r_num[23]};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_total});
    assign w_div_sub = w_div_sh[9:0] - r_total;

    // Square-root step: bring down two radicand bits, trial = 4*root + 1.
    // Remainder never exceeds 2*root, so 10 bits hold it after subtraction.
    logic [11:0] w_sq_sh;
    logic [11:0] w_trial;
    logic        w_sq_ge;
    logic [9:0]  w_sq_sub;
    assign w_sq_sh  = {r_srem, r_num[15:14]};
    assign w_trial  = {2'b00, r_root, 2'b01};
    assign w_sq_ge  = (w_sq_sh >= w_trial);
    assign w_sq_sub = w_sq_sh[9:0] - w_trial[9:0];

    logic [8:0] w_store;
`ifdef STATEPREP_ROUND_EN
    // rem > r means q is closer to (r+1)^2 than to r^2
    assign w_store = {1'b0, r_root} + {8'd0, (r_srem > {2'b00, r_root})};
`else
    assign w_store = {1'b0, r_root};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_total <= '0;
            r_k     <= '0;
            r_bit   <= '0;
            r_num   <= '0;
            r_drem  <= '0;
            r_root  <= '0;
            r_srem  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
                r_amp[i]    <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_done high means this is the cycle right after FIN,
                    // where a start request is deliberately ignored.
                    if (start && !r_done) begin
                        r_cnt[0] <= count0;
                        r_cnt[1] <= count1;
                        r_cnt[2] <= count2;
                        r_cnt[3] <= count3;
                        r_busy   <= 1'b1;
                        r_state  <= S_SUM;
                    end
                end
                S_SUM: begin
                    r_total <= 10'(r_cnt[0]) + 10'(r_cnt[1])
                             + 10'(r_cnt[2]) + 10'(r_cnt[3]);
                    r_k     <= '0;
                    if ((r_cnt[0] | r_cnt[1] | r_cnt[2] | r_cnt[3]) == 8'd0) begin
                        r_shadow[0] <= c_AMP_ONE;
                        r_shadow[1] <= '0;
                        r_shadow[2] <= '0;
                        r_shadow[3] <= '0;
                        r_state     <= S_FIN;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_num   <= 24'(r_cnt[r_k]) * 24'(c_AMP_SQ);
                    r_drem  <= '0;
                    r_root  <= '0;
                    r_srem  <= '0;
                    r_bit   <= '0;
                    r_state <= S_DIV;
                end
                S_DIV: begin
                    r_drem <= w_div_ge ? w_div_sub : w_div_sh[9:0];
                    r_num  <= {r_num[22:0], w_div_ge};
                    if (r_bit == 5'd23) begin
                        r_bit   <= '0;
                        r_state <= S_SQRT;
                    end else begin
                        r_bit <= r_bit + 5'd1;
                    end
                end
                S_SQRT: begin
                    r_srem <= w_sq_ge ? w_sq_sub : w_sq_sh[9:0];
                    r_root <= {r_root[6:0], w_sq_ge};
                    r_num  <= {r_num[21:0], 2'b00};
                    if (r_bit == 5'd7) begin
                        r_bit   <= '0;
                        r_state <= S_STORE;
                    end else begin
                        r_bit <= r_bit + 5'd1;
                    end
                end
                S_STORE: begin
                    r_shadow[r_k] <= w_store;
                    if (r_k == 2'd3) begin
                        r_state <= S_FIN;
                    end else begin
                        r_k     <= r_k + 2'd1;
                        r_state <= S_MUL;
                    end
                end
                S_FIN: begin
                    // whole vector updates in one edge
                    for (int i = 0; i < 4; i++) begin
                        r_amp[i] <= r_shadow[i];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign amp00_real = AMP_W'(r_amp[0]);
    assign amp01_real = AMP_W'(r_amp[1]);
    assign amp10_real = AMP_W'(r_amp[2]);
    assign amp11_real = AMP_W'(r_amp[3]);
    assign amp00_imag = '0;
    assign amp01_imag = '0;
    assign amp10_imag = '0;
    assign amp11_imag = '0;

endmodule
`default_nettype wire

// File: tb/tb_state_preparation.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_preparation
//  Description : Self-checking bench for state_preparation. Expected values
//                come from an arithmetic model of the histogram-to-amplitude
//                rule (integer division and integer square root).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_state_preparation;

    localparam int AMP_ONE = 181;
    localparam int AMP_W   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] count0 = '0, count1 = '0, count2 = '0, count3 = '0;
    logic busy, done;
    logic signed [AMP_W-1:0] amp00_real, amp00_imag, amp01_real, amp01_imag;
    logic signed [AMP_W-1:0] amp10_real, amp10_imag, amp11_real, amp11_imag;

    state_preparation #(.AMP_ONE(AMP_ONE), .AMP_W(AMP_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3),
        .busy(busy), .done(done),
        .amp00_real(amp00_real), .amp00_imag(amp00_imag),
        .amp01_real(amp01_real), .amp01_imag(amp01_imag),
        .amp10_real(amp10_real), .amp10_imag(amp10_imag),
        .amp11_real(amp11_real), .amp11_imag(amp11_imag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: amp = isqrt(c*A^2/total), optionally rounded to nearest.
    function automatic int model_amp(input int c0, input int c1, input int c2,
                                     input int c3, input int k);
        int c[4];
        int total, q, r;
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        total = c0 + c1 + c2 + c3;
        if (total == 0) return (k == 0) ? AMP_ONE : 0;
        q = ((c[k] * AMP_ONE * AMP_ONE) / total) & 16'hFFFF;
        r = 0;
        while ((r + 1) * (r + 1) <= q) r++;
`ifdef STATEPREP_ROUND_EN
        if (q - r * r > r) r++;
`endif
        return r;
    endfunction

    task automatic check_amps(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
        check({tag, " amp00_real"}, amp00_real, e0);
        check({tag, " amp01_real"}, amp01_real, e1);
        check({tag, " amp10_real"}, amp10_real, e2);
        check({tag, " amp11_real"}, amp11_real, e3);
        check({tag, " imag"}, {amp00_imag | amp01_imag | amp10_imag | amp11_imag}, 0);
    endtask

    // One full operation; ignore_at >= 0 pulses a second start mid-run.
    task automatic run_op(input string tag, input int c0, input int c1,
                          input int c2, input int c3, input int ignore_at);
        int e[4];
        int lat_exp, cyc, busy_bad, sumsq;
        for (int k = 0; k < 4; k++) e[k] = model_amp(c0, c1, c2, c3, k);
        lat_exp = (c0 + c1 + c2 + c3 == 0) ? 2 : 138;
        count0 = 8'(c0); count1 = 8'(c1); count2 = 8'(c2); count3 = 8'(c3);
        start = 1'b1;
        tick();
        start = 1'b0;
        // inputs are latched; disturb them
        count0 = 8'($urandom); count1 = 8'($urandom);
        count2 = 8'($urandom); count3 = 8'($urandom);
        cyc = 0;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 300) begin
            if (busy !== 1'b1) busy_bad++;
            if (cyc == ignore_at) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, cyc, lat_exp);
        check({tag, " busy during run"}, busy_bad, 0);
        check({tag, " busy at done"}, busy, 0);
        check_amps(tag, e[0], e[1], e[2], e[3]);
        sumsq = amp00_real * amp00_real + amp01_real * amp01_real
              + amp10_real * amp10_real + amp11_real * amp11_real;
        check({tag, " norm bound"}, sumsq <= AMP_ONE * AMP_ONE, 1);
        // start during the done cycle must be ignored
        count0 = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " single done"}, done, 0);
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) busy_bad++;
            tick();
        end
        check({tag, " start at done ignored"}, busy_bad, 0);
        check_amps({tag, " hold"}, e[0], e[1], e[2], e[3]);
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check_amps("reset", 0, 0, 0, 0);

        run_op("c128_128", 128, 128, 0, 0, -1);
        run_op("c255", 255, 0, 0, 0, -1);
        run_op("c1111", 1, 1, 1, 1, -1);
        check("1111 four*90^2 bound", 4 * amp00_real * amp00_real <= AMP_ONE * AMP_ONE, 1);
        run_op("c0000", 0, 0, 0, 0, -1);
        run_op("c0_0_0_200", 0, 0, 0, 200, -1);
        run_op("ignore_start", 50, 60, 70, 80, 10);

        // reset mid-run aborts with no done pulse
        count0 = 8'd9; count1 = 8'd3; count2 = 8'd0; count3 = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check_amps("abort", 0, 0, 0, 0);
        ndone = 0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1 || busy === 1'b1) ndone++;
            tick();
        end
        check("abort no done", ndone, 0);
        run_op("after_abort", 9, 3, 0, 1, -1);

        // randomized histograms
        for (int i = 0; i < 8; i++) begin
            int a, b, c, d;
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            c = $urandom_range(0, 255); d = $urandom_range(0, 255);
            if (i == 5) begin
                a = 0; b = 0; c = 0; d = 0;
            end
            if (i == 6) begin
                a = 0; b = $urandom_range(1, 3); c = 0; d = 0;
            end
            run_op($sformatf("rand%0d", i), a, b, c, d, -1);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/state_preparation.md
Name: state_preparation

Overview:
- Inverse of the measurement block: converts a 4-bin |00>..|11> histogram (8-bit counts) into the 2-qubit amplitude vector that the measurement block consumes.
- Each output amplitude is amp_k = floor(sqrt(count_k * AMP_ONE^2 / total)), where total = sum of the four counts.
- Imag parts are always zero.
- Sequential: bit-serial restoring divider plus bit-serial integer square root, shared across the four bins by one FSM.

Parameters:
- AMP_ONE, 181: amplitude code for probability 1.0 (1/sqrt2 maps to 128). Range 1..255.
- AMP_W, 16: width of each signed amplitude output.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; counts sampled on this edge when idle
- count0..count3  in  8 each  histogram bins for |00>,|01>,|10>,|11>
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; amplitudes are valid from this cycle
- amp00_real, amp00_imag, amp01_real, amp01_imag, amp10_real, amp10_imag, amp11_real, amp11_imag  out  AMP_W signed each  amplitude vector

Behaviour:
- Reset (sync, active-high):
  - FSM goes to IDLE.
  - busy=0, done=0, all amp outputs=0.
  - All internal registers are cleared.
  - Reset mid-operation aborts the computation; no done pulse is produced.
- IDLE: on start=1, latch count0..3 into internal registers and go to SUM.
  - Later changes on count inputs have no effect until the next accepted start.
- SUM (1 cycle): total = c0+c1+c2+c3, 10 bits unsigned.
  - total==0: shadow vector = {AMP_ONE,0,0,0}, go to FIN.
  - Otherwise set k=0 and go to MUL.
- MUL (1 cycle): num = c_k * AMP_ONE^2, 24-bit unsigned.
- DIV (24 cycles): restoring division, 1 quotient bit per cycle, MSB first, q = floor(num/total).
  - q <= AMP_ONE^2 <= 65025, so q fits in 16 bits. Upper quotient bits are truncated.
- SQRT (8 cycles): restoring integer square root, 1 result bit per cycle, r = floor(sqrt(q)), 8 bits. Also keeps remainder rem = q - r^2.
- STORE (1 cycle): shadow_k = r, zero-extended to AMP_W.
  - If k==3, go to FIN. Otherwise k=k+1 and go to MUL.
- FIN (1 cycle):
  - Copy all four shadow values to the amp*_real outputs at the same time. Outputs never show a partially updated vector.
  - amp*_imag = 0.
  - done=1 for this cycle, busy=0 the following cycle, return to IDLE.
- Latency:
  - Start accepted at edge N → done high in the cycle after edge N+1+4*34+1 = N+138.
  - For total==0 the done pulse comes after edge N+2.
- busy is high in every non-IDLE state except the FIN cycle.
- start while busy is ignored. It is neither queued nor does it restart the computation.
- start in the same cycle as done (FIN) is ignored. A new start is accepted from the next IDLE cycle.
- Outputs hold their last value until the next FIN or reset.
- Invariant: sum of amp_k^2 <= AMP_ONE^2.

Optional Feature:
- Macro: STATEPREP_ROUND_EN.
- Defined: in STORE, if rem > r then shadow_k = r+1, otherwise r. This is round-to-nearest sqrt. No extra cycles; latency unchanged.
- Undefined: floor result as above.
- The total==0 path is identical in both builds.

Test Plan:
- Counts 128,128,0,0 (q=16380, r=127, rem=251) → done 138 cycles after start, amp00_real=amp01_real=127, others 0. With STATEPREP_ROUND_EN: 128,128.
- Counts 255,0,0,0 → amp00_real=181, amp01/10/11_real=0, all imag=0; same result with or without rounding.
- Counts 1,1,1,1 (q=8190, r=90, rem=90) → all four real outputs 90 in both builds; check 4*90^2 <= 181^2.
- Counts 0,0,0,0 → done 2 cycles after start, vector {181,0,0,0}. Then counts 0,0,0,200 → amp11_real=181, others 0.
- Pulse start again 10 cycles into a run with different counts → ignored: one done pulse only, result matches the first counts, busy stays high throughout.
- Assert reset 50 cycles into a run → the next cycle shows busy=0, done=0, all amps 0, with no done pulse. A fresh start then completes normally in 138 cycles.
